// File: rtl/irq_ctrl_if.sv
// Bridge-side slave bus for irq_ctrl: window select, word offset, write strobe,
// byte enables, write data and combinational read data.
interface irq_ctrl_if;
  logic        sel;
  logic [2:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, addr, we, byteen, wdata, input rdata);
  modport slave  (input sel, addr, we, byteen, wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised level/edge sources, software mask, registered HWInt vector.
// Optional macro IRQC_PRIORITY_EN adds a lowest-index-wins priority readout at offset 4.
module irq_ctrl #(
  parameter int unsigned N_SRC       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  irq_ctrl_if.slave        bus,
  output logic [5:0]       hwint,
  output logic             irq_any
);

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] syn;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] active;
  logic [5:0]       hw_next;
  logic             wr_ok;
  logic [31:0]      prio;
  logic [31:0]      rd;
  logic             unused_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= src;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign syn    = sync_q[SYNC_STAGES-1];
  assign rise   = syn & ~prev;
  assign wr_ok  = bus.sel & bus.we & (bus.byteen == 4'b1111);
  assign clr    = (wr_ok && bus.addr == 3'd0) ? bus.wdata[N_SRC-1:0] : '0;
  assign active = pend & mask;

  always_comb begin
    hw_next = '0;
    hw_next[N_SRC-1:0] = active;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev  <= '0;
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      hwint <= '0;
    end else begin
      prev  <= syn;
      hwint <= hw_next;
      // Edge bits: a new edge beats a simultaneous W1C; level bits track syn.
      pend  <= (mode & ((pend & ~clr) | rise)) | (~mode & syn);
      if (wr_ok && bus.addr == 3'd1) mask <= bus.wdata[N_SRC-1:0];
      if (wr_ok && bus.addr == 3'd2) mode <= bus.wdata[N_SRC-1:0];
    end
  end

  assign irq_any = |hwint;

`ifdef IRQC_PRIORITY_EN
  always_comb begin
    logic found;
    found = 1'b0;
    prio  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (active[i] && !found) begin
        found     = 1'b1;
        prio[2:0] = 3'(i);
      end
    end
    prio[31] = |active;
  end
`else
  assign prio = '0;
`endif

  always_comb begin
    rd = '0;
    if (bus.sel) begin
      case (bus.addr)
        3'd0:    rd[N_SRC-1:0] = pend;
        3'd1:    rd[N_SRC-1:0] = mask;
        3'd2:    rd[N_SRC-1:0] = mode;
        3'd3:    rd[N_SRC-1:0] = syn;
        3'd4:    rd = prio;
        default: rd = '0;
      endcase
    end
  end

  assign bus.rdata    = rd;
  assign unused_wdata = ^bus.wdata[31:N_SRC];

endmodule
